// File: rtl/stall_hold_ctrl.sv
// Stall/flush hold controller: captures synchronous-read memory data into a
// last-result register while the pipeline stalls and substitutes a bubble on flush.
module stall_hold_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_CH    = 2,
  parameter logic [31:0] FLUSH_VAL = 32'h00000013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic [NUM_CH*DATA_W-1:0] raw_data_i,
  output logic [NUM_CH*DATA_W-1:0] data_o,
  output logic                     choice_flag_o,
  output logic                     hold_valid_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         stall_max_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Bubble word per channel: the low DATA_W bits of FLUSH_VAL, zero-extended if wider.
  localparam logic [DATA_W+31:0]    FLUSH_EXT = {{DATA_W{1'b0}}, FLUSH_VAL};
  localparam logic [DATA_W-1:0]     FLUSH_CH  = FLUSH_EXT[DATA_W-1:0];
  localparam logic [CNT_W-1:0]      CNT_SAT   = {CNT_W{1'b1}};

  state_t                     state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]   lr_q, lr_d;
  logic [NUM_CH*DATA_W-1:0]   flush_word;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           max_q, max_d;

  always_comb begin
    flush_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      flush_word[k*DATA_W +: DATA_W] = FLUSH_CH;
    end
  end

  // Next-state and lr decode; flush outranks every other condition.
  always_comb begin
    state_d = state_q;
    lr_d    = lr_q;
    if (flush_i) begin
      state_d = ST_FLUSH;
      lr_d    = flush_word;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stall_i) begin
            state_d = ST_HOLD;
            lr_d    = raw_data_i;
          end
        end
        ST_HOLD: begin
          if (!stall_i) state_d = ST_RUN;
        end
        ST_FLUSH: begin
          if (!stall_i) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Stall run length saturates rather than wraps so the max never looks short.
  always_comb begin
    cnt_d = '0;
    if (stall_i) begin
      cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    end
    max_d = (cnt_d > max_q) ? cnt_d : max_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      lr_q    <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      lr_q    <= lr_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
    end
  end

  // hold_valid_o is a level, not a handshake: high exactly while lr carries
  // captured memory data; there is no ready side and nothing is consumed.
  always_comb begin
    choice_flag_o = (state_q != ST_RUN);
    hold_valid_o  = (state_q == ST_HOLD);
    data_o        = choice_flag_o ? lr_q : raw_data_i;
    stall_cnt_o   = cnt_q;
    stall_max_o   = max_q;
    state_o       = state_q;
  end

endmodule
